dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Sequencer and arbiter for the single-port data memory, shared between two requesters: the pipeline MEM stage (CPU port) and a debug/loader port. It owns the memory enable/address/data lines and counts the fixed memory read latency. It stalls the pipeline while a CPU access is outstanding, and applies round-robin priority when both ports request in the same cycle.

Parameters:
ADDR_W, 5, word-address width to memory (32 words)
LATENCY, 1, cycles from the mem_en_o sample edge to valid mem_rdata_i; legal range 1..4

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
cpu_req_i  in  1  MEM-stage access request, held until cpu_done_o
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  write data
cpu_rdata_o  out  32  read data, valid while cpu_done_o=1
cpu_done_o  out  1  one-cycle completion pulse
cpu_stall_o  out  1  pipeline stall
dbg_valid_i  in  1  debug request valid
dbg_ready_o  out  1  debug request accepted when valid&ready
dbg_we_i  in  1  1=write
dbg_addr_i  in  32  byte address
dbg_wdata_i  in  32  write data
dbg_rdata_o  out  32  read data, valid while dbg_done_o=1
dbg_done_o  out  1  one-cycle completion pulse (reads and writes)
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  word address = addr[ADDR_W+1:2]
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data

Behaviour:
- Reset: state IDLE; mem_en_o/mem_we_o/cpu_done_o/dbg_done_o=0; rdata registers, mem_addr_o, mem_wdata_o=0; rr pointer=CPU.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE (grant cycle): if exactly one requester is active (cpu_req_i, or dbg_valid_i), grant it. If both are active, grant the one the rr pointer names. At the edge, latch owner, we, word address and wdata; rr pointer flips to the non-granted port; go to ISSUE. With no request, stay in IDLE.
- dbg_ready_o = (state==IDLE) & ~(cpu_req_i & (rr==CPU | ~dbg_valid_i)). It is low in every non-IDLE state.
- ISSUE: registered mem_en_o=1 for exactly this cycle; mem_we_o, mem_addr_o and mem_wdata_o are driven from latched values. A write goes to RESP. A read loads the counter with LATENCY-1 and goes to WAIT.
- WAIT: when the counter reaches 0, capture mem_rdata_i into the owner's rdata register and go to RESP; otherwise decrement. WAIT lasts exactly LATENCY cycles.
- RESP: the owner's done pulse is high for one cycle; then go to IDLE. New requests are never granted in RESP.
- Latency, request seen in IDLE at cycle 0: write done at cycle 2; read done at cycle LATENCY+2. Back-to-back accesses add the IDLE cycle.
- cpu_stall_o = cpu_req_i & ~cpu_done_o (combinational). The pipeline advances on the done edge.
- Non-granted requester: CPU keeps its request held (stalled); debug keeps valid asserted, and its payload must stay stable until accepted.
- Address bits [1:0] and bits above ADDR_W+1 are ignored (word access only).
- rdata outputs hold their last captured value between pulses.
- Reset mid-operation: the next cycle is IDLE with no done pulse. A write already strobed in ISSUE is not rolled back.
- cpu_req_i dropped while granted is a protocol error. The access completes anyway and cpu_done_o still pulses.

Test Plan:
- Reset, then memory[2]=10 and CPU read 0x08 at cycle 0 (LATENCY=1) -> mem_en_o=1, mem_addr_o=2 in cycle 1; cpu_done_o=1, cpu_rdata_o=10 in cycle 3; cpu_stall_o=1 in cycles 0-2 and 0 in cycle 3.
- CPU write 0x14 data 42, then CPU read 0x14 -> mem_we_o=1, mem_addr_o=5 in cycle 1; done in cycle 2; the read returns 42 in cycle 6.
- After reset, CPU read and debug write 0x00 data 7 both asserted in cycle 0 -> CPU is granted and dbg_ready_o=0. CPU done in cycle 3. Debug is accepted in cycle 4 and done in cycle 6; memory[0]=7.
- Both ports issue continuous requests -> grants alternate CPU, DBG, CPU, DBG; neither port waits more than one foreign access.
- rst_i asserted during WAIT (LATENCY=3, read) -> IDLE next cycle; no cpu_done_o; mem_en_o=0; cpu_stall_o stays high while cpu_req_i=1; the request is re-granted after reset is released.
- LATENCY=3, debug read 0x10 with memory[4]=29 -> dbg_done_o=1, dbg_rdata_o=29 exactly 5 cycles after acceptance; dbg_ready_o=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory sequencer shared by the MEM-stage CPU port and a debug/loader port.
// Round-robin arbitration on simultaneous requests; counts the fixed read latency.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_done_o,
  output logic              cpu_stall_o,
  input  logic              dbg_valid_i,
  output logic              dbg_ready_o,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic [31:0]       dbg_rdata_o,
  output logic              dbg_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned       CNT_W    = 2;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic              PORT_CPU = 1'b0;
  localparam logic              PORT_DBG = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [31:0]        mem_wdata_d;
  logic               cpu_done_d, dbg_done_d;
  logic [31:0]        cpu_rdata_d, dbg_rdata_d;
  logic               grant_cpu, grant_dbg;
  logic               unused_addr_bits;

  // Byte-offset and out-of-range address bits are irrelevant for word access.
  assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0],
                              dbg_addr_i[31:ADDR_W+2], dbg_addr_i[1:0]};

  assign grant_cpu   = cpu_req_i & ((rr_q == PORT_CPU) | ~dbg_valid_i);
  assign grant_dbg   = dbg_valid_i & ~grant_cpu;
  assign dbg_ready_o = (state_q == IDLE) & ~grant_cpu;
  assign cpu_stall_o = cpu_req_i & ~cpu_done_o;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    cpu_done_d  = 1'b0;
    dbg_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_o;
    dbg_rdata_d = dbg_rdata_o;
    case (state_q)
      IDLE: begin
        if (grant_cpu | grant_dbg) begin
          owner_d     = grant_dbg ? PORT_DBG : PORT_CPU;
          rr_d        = grant_dbg ? PORT_CPU : PORT_DBG;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dbg ? dbg_we_i : cpu_we_i;
          mem_addr_d  = grant_dbg ? dbg_addr_i[ADDR_W+1:2] : cpu_addr_i[ADDR_W+1:2];
          mem_wdata_d = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_o) begin
          cpu_done_d = (owner_q == PORT_CPU);
          dbg_done_d = (owner_q == PORT_DBG);
          state_d    = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == PORT_CPU) cpu_rdata_d = mem_rdata_i;
          else                     dbg_rdata_d = mem_rdata_i;
          cpu_done_d = (owner_q == PORT_CPU);
          dbg_done_d = (owner_q == PORT_DBG);
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= PORT_CPU;
      rr_q        <= PORT_CPU;
      cnt_q       <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_done_o  <= 1'b0;
      dbg_done_o  <= 1'b0;
      cpu_rdata_o <= '0;
      dbg_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      mem_en_o    <= mem_en_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      cpu_done_o  <= cpu_done_d;
      dbg_done_o  <= dbg_done_d;
      cpu_rdata_o <= cpu_rdata_d;
      dbg_rdata_o <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance a uses LATENCY=1, instance b LATENCY=3,
// each backed by a small fixed-latency memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic        a_rst, a_cpu_req, a_cpu_we, a_cpu_done, a_cpu_stall;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_dbg_valid, a_dbg_ready, a_dbg_we, a_dbg_done;
  logic [31:0] a_dbg_addr, a_dbg_wdata, a_dbg_rdata;
  logic        a_mem_en, a_mem_we;
  logic [4:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;

  logic        b_rst, b_cpu_req, b_cpu_we, b_cpu_done, b_cpu_stall;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_dbg_valid, b_dbg_ready, b_dbg_we, b_dbg_done;
  logic [31:0] b_dbg_addr, b_dbg_wdata, b_dbg_rdata;
  logic        b_mem_en, b_mem_we;
  logic [4:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  logic        ld_a, ld_b;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] pipe_b [3];

  int own [4];
  int cyc [4];
  int exp_own [4] = '{0, 1, 0, 1};
  int exp_cyc [4] = '{3, 6, 10, 13};
  int n;

  dmem_arbiter #(.ADDR_W(5), .LATENCY(1)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .cpu_req_i(a_cpu_req), .cpu_we_i(a_cpu_we), .cpu_addr_i(a_cpu_addr),
    .cpu_wdata_i(a_cpu_wdata), .cpu_rdata_o(a_cpu_rdata), .cpu_done_o(a_cpu_done),
    .cpu_stall_o(a_cpu_stall),
    .dbg_valid_i(a_dbg_valid), .dbg_ready_o(a_dbg_ready), .dbg_we_i(a_dbg_we),
    .dbg_addr_i(a_dbg_addr), .dbg_wdata_i(a_dbg_wdata), .dbg_rdata_o(a_dbg_rdata),
    .dbg_done_o(a_dbg_done),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(5), .LATENCY(3)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr),
    .cpu_wdata_i(b_cpu_wdata), .cpu_rdata_o(b_cpu_rdata), .cpu_done_o(b_cpu_done),
    .cpu_stall_o(b_cpu_stall),
    .dbg_valid_i(b_dbg_valid), .dbg_ready_o(b_dbg_ready), .dbg_we_i(b_dbg_we),
    .dbg_addr_i(b_dbg_addr), .dbg_wdata_i(b_dbg_wdata), .dbg_rdata_o(b_dbg_rdata),
    .dbg_done_o(b_dbg_done),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // Memory a: read data valid one cycle after the strobe edge, garbage otherwise
  always @(posedge clk) begin
    if (ld_a) mem_a[ld_addr] <= ld_data;
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 32'hDEAD_BEEF;
  end

  // Memory b: three-stage read pipeline
  always @(posedge clk) begin
    if (ld_b) mem_b[ld_addr] <= ld_data;
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel_b, input logic [4:0] addr, input logic [31:0] d);
    ld_a = ~sel_b; ld_b = sel_b; ld_addr = addr; ld_data = d;
    step();
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = '0; a_cpu_wdata = '0;
    a_dbg_valid = 1'b0; a_dbg_we = 1'b0; a_dbg_addr = '0; a_dbg_wdata = '0;
    b_rst = 1'b1; b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dbg_valid = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = '0; b_dbg_wdata = '0;
    ld_a = 1'b0; ld_b = 1'b0; ld_addr = '0; ld_data = '0;

    load(1'b0, 5'd2, 32'd10);
    load(1'b1, 5'd2, 32'd11);
    load(1'b1, 5'd4, 32'd29);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk1("rst_mem_en", a_mem_en, 1'b0);
    chk1("rst_mem_we", a_mem_we, 1'b0);
    chk1("rst_cpu_done", a_cpu_done, 1'b0);
    chk1("rst_dbg_done", a_dbg_done, 1'b0);
    chk("rst_cpu_rdata", a_cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", a_dbg_rdata, 32'd0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'd0);
    chk1("rst_dbg_ready", a_dbg_ready, 1'b1);
    chk1("rst_stall", a_cpu_stall, 1'b0);

    // CPU read of word 2, LATENCY=1
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h08;
    #1;
    chk1("t1_c0_stall", a_cpu_stall, 1'b1);
    chk1("t1_c0_ready", a_dbg_ready, 1'b0);
    step(); #1;
    chk1("t1_c1_en", a_mem_en, 1'b1);
    chk1("t1_c1_we", a_mem_we, 1'b0);
    chk("t1_c1_addr", 32'(a_mem_addr), 32'd2);
    chk1("t1_c1_stall", a_cpu_stall, 1'b1);
    step(); #1;
    chk1("t1_c2_en", a_mem_en, 1'b0);
    chk1("t1_c2_done", a_cpu_done, 1'b0);
    chk1("t1_c2_stall", a_cpu_stall, 1'b1);
    step(); #1;
    chk1("t1_c3_done", a_cpu_done, 1'b1);
    chk("t1_c3_rdata", a_cpu_rdata, 32'd10);
    chk1("t1_c3_stall", a_cpu_stall, 1'b0);

    // Back-to-back CPU write 0x14 <= 42, then read it back
    step();
    a_cpu_we = 1'b1; a_cpu_addr = 32'h14; a_cpu_wdata = 32'd42;
    #1;
    chk1("t2_c0_done", a_cpu_done, 1'b0);
    chk("t2_c0_rdata_hold", a_cpu_rdata, 32'd10);
    step(); #1;
    chk1("t2_c1_en", a_mem_en, 1'b1);
    chk1("t2_c1_we", a_mem_we, 1'b1);
    chk("t2_c1_addr", 32'(a_mem_addr), 32'd5);
    chk("t2_c1_wdata", a_mem_wdata, 32'd42);
    step(); #1;
    chk1("t2_c2_done", a_cpu_done, 1'b1);
    chk1("t2_c2_stall", a_cpu_stall, 1'b0);
    step();
    a_cpu_we = 1'b0;
    #1;
    chk1("t2_c3_done", a_cpu_done, 1'b0);
    chk1("t2_c3_stall", a_cpu_stall, 1'b1);
    step(); #1;
    chk1("t2_c4_en", a_mem_en, 1'b1);
    chk1("t2_c4_we", a_mem_we, 1'b0);
    step(); #1;
    chk1("t2_c5_done", a_cpu_done, 1'b0);
    step(); #1;
    chk1("t2_c6_done", a_cpu_done, 1'b1);
    chk("t2_c6_rdata", a_cpu_rdata, 32'd42);
    chk("t2_mem5", mem_a[5], 32'd42);
    step();
    a_cpu_req = 1'b0; a_rst = 1'b1;
    #1;
    chk1("t2_c7_stall", a_cpu_stall, 1'b0);

    // After reset: simultaneous CPU read and debug write, CPU wins
    step();
    a_rst = 1'b0;
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h08;
    a_dbg_valid = 1'b1; a_dbg_we = 1'b1; a_dbg_addr = 32'h00; a_dbg_wdata = 32'd7;
    #1;
    chk1("t3_c0_ready", a_dbg_ready, 1'b0);
    chk1("t3_c0_stall", a_cpu_stall, 1'b1);
    step(); #1;
    chk1("t3_c1_en", a_mem_en, 1'b1);
    chk1("t3_c1_we", a_mem_we, 1'b0);
    chk("t3_c1_addr", 32'(a_mem_addr), 32'd2);
    chk1("t3_c1_ready", a_dbg_ready, 1'b0);
    step();
    step(); #1;
    chk1("t3_c3_cpu_done", a_cpu_done, 1'b1);
    chk("t3_c3_rdata", a_cpu_rdata, 32'd10);
    chk1("t3_c3_dbg_done", a_dbg_done, 1'b0);
    step();
    a_cpu_req = 1'b0;
    #1;
    chk1("t3_c4_ready", a_dbg_ready, 1'b1);
    step();
    a_dbg_valid = 1'b0;
    #1;
    chk1("t3_c5_en", a_mem_en, 1'b1);
    chk1("t3_c5_we", a_mem_we, 1'b1);
    chk("t3_c5_addr", 32'(a_mem_addr), 32'd0);
    chk("t3_c5_wdata", a_mem_wdata, 32'd7);
    step(); #1;
    chk1("t3_c6_dbg_done", a_dbg_done, 1'b1);
    chk1("t3_c6_cpu_done", a_cpu_done, 1'b0);
    step(); #1;
    chk1("t3_c7_dbg_done", a_dbg_done, 1'b0);
    chk("t3_mem0", mem_a[0], 32'd7);

    // Both ports requesting continuously: grants alternate
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h08;
    a_dbg_valid = 1'b1; a_dbg_we = 1'b1; a_dbg_addr = 32'hFFFF_FF0F; a_dbg_wdata = 32'd55;
    n = 0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      #1;
      if (k == 4) chk1("t4_c4_ready", a_dbg_ready, 1'b1);
      if (k == 7) chk1("t4_c7_ready", a_dbg_ready, 1'b0);
      if (a_cpu_done && n < 4) begin own[n] = 0; cyc[n] = k; n++; end
      if (a_dbg_done && n < 4) begin own[n] = 1; cyc[n] = k; n++; end
    end
    chk("t4_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_owner%0d", i), own[i], exp_own[i]);
      chk($sformatf("t4_cycle%0d", i), cyc[i], exp_cyc[i]);
    end
    step();
    a_cpu_req = 1'b0; a_dbg_valid = 1'b0;
    chk("t4_mem3", mem_a[3], 32'd55);

    // LATENCY=3: reset during WAIT, then re-grant
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h08;
    #1;
    chk1("t5_c0_stall", b_cpu_stall, 1'b1);
    step(); #1;
    chk1("t5_c1_en", b_mem_en, 1'b1);
    chk("t5_c1_addr", 32'(b_mem_addr), 32'd2);
    step();
    step();
    b_rst = 1'b1;
    #1;
    chk1("t5_c3_done", b_cpu_done, 1'b0);
    step();
    b_rst = 1'b0;
    #1;
    chk1("t5_c4_done", b_cpu_done, 1'b0);
    chk1("t5_c4_en", b_mem_en, 1'b0);
    chk1("t5_c4_stall", b_cpu_stall, 1'b1);
    chk1("t5_c4_ready", b_dbg_ready, 1'b0);
    step(); #1;
    chk1("t5_c5_en", b_mem_en, 1'b1);
    chk1("t5_c5_done", b_cpu_done, 1'b0);
    for (int k = 6; k < 9; k++) begin
      step(); #1;
      chk1($sformatf("t5_c%0d_done", k), b_cpu_done, 1'b0);
    end
    step(); #1;
    chk1("t5_c9_done", b_cpu_done, 1'b1);
    chk("t5_c9_rdata", b_cpu_rdata, 32'd11);
    chk1("t5_c9_stall", b_cpu_stall, 1'b0);

    // LATENCY=3: debug read of word 4
    step();
    b_cpu_req = 1'b0;
    b_dbg_valid = 1'b1; b_dbg_we = 1'b0; b_dbg_addr = 32'h10;
    #1;
    chk1("t6_c0_ready", b_dbg_ready, 1'b1);
    step();
    b_dbg_valid = 1'b0;
    #1;
    chk1("t6_c1_en", b_mem_en, 1'b1);
    chk("t6_c1_addr", 32'(b_mem_addr), 32'd4);
    chk1("t6_c1_ready", b_dbg_ready, 1'b0);
    for (int k = 2; k < 5; k++) begin
      step(); #1;
      chk1($sformatf("t6_c%0d_ready", k), b_dbg_ready, 1'b0);
      chk1($sformatf("t6_c%0d_done", k), b_dbg_done, 1'b0);
    end
    step(); #1;
    chk1("t6_c5_done", b_dbg_done, 1'b1);
    chk("t6_c5_rdata", b_dbg_rdata, 32'd29);
    chk1("t6_c5_ready", b_dbg_ready, 1'b0);
    chk("t6_c5_cpu_rdata_hold", b_cpu_rdata, 32'd11);
    step(); #1;
    chk1("t6_c6_done", b_dbg_done, 1'b0);
    chk("t6_c6_rdata_hold", b_dbg_rdata, 32'd29);
    chk1("t6_c6_ready", b_dbg_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
